// File: rtl/alu_uart_interface.sv
// Byte-stream sequencer: loads A, B and opcode into the ALU, then returns ALU_Result as one UART byte.
// Optional opcode validation is enabled with the ALU_IF_OPCHECK_EN macro.
module alu_uart_interface #(
  parameter int NBITS       = 8,
  parameter int COD_OP      = 6,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NBITS-1:0]  i_rx_data,
  input  logic              i_rx_valid,
  input  logic              i_tx_done,
  output logic [NBITS-1:0]  o_tx_data,
  output logic              o_tx_start,
  output logic [NBITS-1:0]  operando_A,
  output logic [NBITS-1:0]  operando_B,
  output logic [COD_OP-1:0] cod_operacion,
  input  logic [NBITS-1:0]  ALU_Result,
  output logic              o_busy,
  output logic              o_error
);

  localparam logic [2:0] GET_A   = 3'd0;
  localparam logic [2:0] GET_B   = 3'd1;
  localparam logic [2:0] GET_OP  = 3'd2;
  localparam logic [2:0] EXEC    = 3'd3;
  localparam logic [2:0] WAIT_TX = 3'd4;

  // A zero timeout still needs a 1-bit counter to keep the declarations legal.
  localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TW-1:0] TO_VAL = TW'(TIMEOUT_CYC);

  logic [2:0]    r_state;
  logic [TW-1:0] r_cnt;
  logic [TW-1:0] w_cnt_next;
  logic          w_counting;
  logic          w_expire;

`ifdef ALU_IF_OPCHECK_EN
  function automatic logic op_supported(input logic [COD_OP-1:0] op);
    case (op)
      COD_OP'(6'h20), COD_OP'(6'h22), COD_OP'(6'h24), COD_OP'(6'h25),
      COD_OP'(6'h26), COD_OP'(6'h27), COD_OP'(6'h03), COD_OP'(6'h02): op_supported = 1'b1;
      default: op_supported = 1'b0;
    endcase
  endfunction
`else
  assign o_error = 1'b0;
`endif

  assign o_busy     = (r_state != GET_A);
  assign w_counting = (r_state == GET_B) || (r_state == GET_OP);
  assign w_cnt_next = (r_cnt == {TW{1'b1}}) ? r_cnt : r_cnt + TW'(1);
  // A byte arriving on the expiry cycle wins over the timeout.
  assign w_expire   = (TIMEOUT_CYC != 0) && w_counting && !i_rx_valid && (w_cnt_next == TO_VAL);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= GET_A;
      r_cnt         <= '0;
      o_tx_data     <= '0;
      o_tx_start    <= 1'b0;
      operando_A    <= '0;
      operando_B    <= '0;
      cod_operacion <= '0;
`ifdef ALU_IF_OPCHECK_EN
      o_error       <= 1'b0;
`endif
    end else begin
      o_tx_start <= 1'b0;
      if (w_counting && !i_rx_valid && !w_expire) begin
        r_cnt <= w_cnt_next;
      end else begin
        r_cnt <= '0;
      end

      case (r_state)
        GET_A: begin
          if (i_rx_valid) begin
            operando_A <= i_rx_data;
            r_state    <= GET_B;
`ifdef ALU_IF_OPCHECK_EN
            o_error    <= 1'b0;
`endif
          end
        end
        GET_B: begin
          if (i_rx_valid) begin
            operando_B <= i_rx_data;
            r_state    <= GET_OP;
          end else if (w_expire) begin
            r_state <= GET_A;
          end
        end
        GET_OP: begin
          if (i_rx_valid) begin
`ifdef ALU_IF_OPCHECK_EN
            if (op_supported(i_rx_data[COD_OP-1:0])) begin
              cod_operacion <= i_rx_data[COD_OP-1:0];
              r_state       <= EXEC;
            end else begin
              o_error <= 1'b1;
              r_state <= GET_A;
            end
`else
            cod_operacion <= i_rx_data[COD_OP-1:0];
            r_state       <= EXEC;
`endif
          end else if (w_expire) begin
            r_state <= GET_A;
          end
        end
        EXEC: begin
          o_tx_data  <= ALU_Result;
          o_tx_start <= 1'b1;
          r_state    <= WAIT_TX;
        end
        WAIT_TX: begin
          if (i_tx_done) begin
            r_state <= GET_A;
          end
        end
        default: r_state <= GET_A;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_uart_interface.sv
// Directed bench for alu_uart_interface: frames, dropped bytes, timeout, mid-frame reset, opcode check.
`timescale 1ns/1ps
module tb_alu_uart_interface;
  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic [7:0] i_rx_data = 8'h00;
  logic       i_rx_valid = 1'b0;
  logic       i_tx_done = 1'b0;
  logic [7:0] o_tx_data;
  logic       o_tx_start;
  logic [7:0] operando_A;
  logic [7:0] operando_B;
  logic [5:0] cod_operacion;
  logic [7:0] ALU_Result;
  logic       o_busy;
  logic       o_error;

  int checks = 0;
  int errors = 0;
  int tx_count = 0;

  alu_uart_interface #(.NBITS(8), .COD_OP(6), .TIMEOUT_CYC(16)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .i_tx_done(i_tx_done), .o_tx_data(o_tx_data), .o_tx_start(o_tx_start),
    .operando_A(operando_A), .operando_B(operando_B), .cod_operacion(cod_operacion),
    .ALU_Result(ALU_Result), .o_busy(o_busy), .o_error(o_error)
  );

  always #5 i_clk = ~i_clk;

  // Reference ALU; unknown codes return a recognisable filler value.
  always_comb begin
    ALU_Result = 8'hEE;
    case (cod_operacion)
      6'h20: ALU_Result = operando_A + operando_B;
      6'h22: ALU_Result = operando_A - operando_B;
      6'h24: ALU_Result = operando_A & operando_B;
      6'h25: ALU_Result = operando_A | operando_B;
      6'h26: ALU_Result = operando_A ^ operando_B;
      6'h27: ALU_Result = ~(operando_A | operando_B);
      6'h03: ALU_Result = $signed(operando_A) >>> operando_B;
      6'h02: ALU_Result = operando_A >> operando_B;
      default: ALU_Result = 8'hEE;
    endcase
  end

  always @(posedge i_clk) begin
    if (o_tx_start === 1'b1) tx_count++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    tick();
    i_rx_valid = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op, input logic [7:0] exp);
    int n0;
    n0 = tx_count;
    send_byte(a);
    send_byte(b);
    send_byte(op);
    checks++; if (operando_A !== a) begin errors++; $display("FAIL opA got %h exp %h", operando_A, a); end
    checks++; if (operando_B !== b) begin errors++; $display("FAIL opB got %h exp %h", operando_B, b); end
    checks++; if (cod_operacion !== op[5:0]) begin errors++; $display("FAIL cod got %h exp %h", cod_operacion, op[5:0]); end
    checks++; if (o_tx_start !== 1'b0) begin errors++; $display("FAIL early_start got %b exp 0", o_tx_start); end
    tick();
    checks++; if (o_tx_start !== 1'b1) begin errors++; $display("FAIL tx_start got %b exp 1", o_tx_start); end
    checks++; if (o_tx_data !== exp) begin errors++; $display("FAIL tx_data op %h got %h exp %h", op, o_tx_data, exp); end
    tick();
    checks++; if (o_tx_start !== 1'b0) begin errors++; $display("FAIL start_pulse_len got %b exp 0", o_tx_start); end
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL busy_wait got %b exp 1", o_busy); end
    i_tx_done = 1'b1;
    tick();
    i_tx_done = 1'b0;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL busy_done got %b exp 0", o_busy); end
    checks++; if (tx_count !== n0 + 1) begin errors++; $display("FAIL tx_count got %0d exp %0d", tx_count, n0 + 1); end
  endtask

  task automatic test_reset;
    repeat (3) tick();
    checks++; if ({o_tx_data, operando_A, operando_B, cod_operacion} !== 30'd0) begin errors++; $display("FAIL reset_regs got %h exp 0", {o_tx_data, operando_A, operando_B, cod_operacion}); end
    checks++; if ({o_tx_start, o_busy, o_error} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {o_tx_start, o_busy, o_error}); end
    i_reset = 1'b0;
    tick();
  endtask

  task automatic test_arith;
    run_frame(8'h04, 8'h0C, 8'h20, 8'h10);
    run_frame(8'h04, 8'h0C, 8'h22, 8'hF8);
    run_frame(8'h04, 8'h0C, 8'h27, 8'hF3);
  endtask

  task automatic test_drop;
    int n0;
    send_byte(8'h0C);
    send_byte(8'h02);
    send_byte(8'h03);
    tick();
    checks++; if (o_tx_data !== 8'h03) begin errors++; $display("FAIL sra got %h exp 03", o_tx_data); end
    tick();
    send_byte(8'h55);
    checks++; if (operando_A !== 8'h0C) begin errors++; $display("FAIL drop_opA got %h exp 0c", operando_A); end
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL drop_busy got %b exp 1", o_busy); end
    n0 = tx_count;
    i_tx_done = 1'b1;
    tick();
    i_tx_done = 1'b0;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL drop_done got %b exp 0", o_busy); end
    checks++; if (tx_count !== n0) begin errors++; $display("FAIL drop_txcnt got %0d exp %0d", tx_count, n0); end
    run_frame(8'h0C, 8'h03, 8'h02, 8'h01);
  endtask

  task automatic test_timeout;
    int n0;
    n0 = tx_count;
    send_byte(8'h05);
    repeat (15) tick();
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL to_early got %b exp 1", o_busy); end
    tick();
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL to_expire got %b exp 0", o_busy); end
    checks++; if (operando_A !== 8'h05) begin errors++; $display("FAIL to_opA got %h exp 05", operando_A); end
    repeat (3) tick();
    checks++; if (tx_count !== n0) begin errors++; $display("FAIL to_notx got %0d exp %0d", tx_count, n0); end
    run_frame(8'h04, 8'h0C, 8'h24, 8'h04);
    // Byte landing on the expiry cycle must be accepted.
    send_byte(8'h07);
    repeat (15) tick();
    send_byte(8'h08);
    checks++; if ({o_busy, operando_B} !== {1'b1, 8'h08}) begin errors++; $display("FAIL to_edge got %h exp 108", {o_busy, operando_B}); end
    send_byte(8'h25);
    tick();
    checks++; if ({o_tx_start, o_tx_data} !== {1'b1, 8'h0F}) begin errors++; $display("FAIL to_edge_tx got %h exp 10f", {o_tx_start, o_tx_data}); end
    tick();
    i_tx_done = 1'b1;
    tick();
    i_tx_done = 1'b0;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL to_edge_done got %b exp 0", o_busy); end
  endtask

  task automatic test_reset_mid;
    int n0;
    send_byte(8'h11);
    send_byte(8'h22);
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL rm_busy got %b exp 1", o_busy); end
    #2 i_reset = 1'b1;
    #1;
    checks++; if ({o_tx_data, operando_A, operando_B, cod_operacion} !== 30'd0) begin errors++; $display("FAIL rm_regs got %h exp 0", {o_tx_data, operando_A, operando_B, cod_operacion}); end
    checks++; if ({o_tx_start, o_busy, o_error} !== 3'b000) begin errors++; $display("FAIL rm_flags got %b exp 000", {o_tx_start, o_busy, o_error}); end
    n0 = tx_count;
    tick();
    i_reset = 1'b0;
    repeat (4) tick();
    checks++; if (tx_count !== n0) begin errors++; $display("FAIL rm_notx got %0d exp %0d", tx_count, n0); end
    run_frame(8'h04, 8'h0C, 8'h20, 8'h10);
  endtask

  task automatic test_opcode;
`ifdef ALU_IF_OPCHECK_EN
    int n0;
    n0 = tx_count;
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h3F);
    checks++; if (o_error !== 1'b1) begin errors++; $display("FAIL oc_err got %b exp 1", o_error); end
    checks++; if (cod_operacion !== 6'h20) begin errors++; $display("FAIL oc_cod got %h exp 20", cod_operacion); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL oc_busy got %b exp 0", o_busy); end
    repeat (3) tick();
    checks++; if (tx_count !== n0) begin errors++; $display("FAIL oc_notx got %0d exp %0d", tx_count, n0); end
    checks++; if (o_error !== 1'b1) begin errors++; $display("FAIL oc_hold got %b exp 1", o_error); end
    run_frame(8'h04, 8'h0C, 8'h20, 8'h10);
`else
    run_frame(8'h01, 8'h02, 8'h3F, 8'hEE);
`endif
    checks++; if (o_error !== 1'b0) begin errors++; $display("FAIL oc_clear got %b exp 0", o_error); end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_drop();
    test_timeout();
    test_reset_mid();
    test_opcode();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
